// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register.
//   Keeps the fetch PC, issues reads to a synchronous instruction memory with
//   one cycle of read latency, and presents {pc_out, instruction_out,
//   valid_out}. A hazard freeze is absorbed by a one-entry skid buffer that
//   catches the response already in flight. branch_taken redirects the fetch
//   and squashes the in-flight response.
//
//   Optional build macro: IF_PERF_COUNTERS_EN
//     When defined, adds saturating 16-bit fetch_count / redirect_count ports.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int             LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           freeze,
    input  logic           branch_taken,
    input  logic [LEN-1:0] branch_addr,
    output logic           imem_rd_en,
    output logic [LEN-1:0] imem_addr,
    input  logic [LEN-1:0] imem_rdata,
    output logic [LEN-1:0] pc_out,
    output logic [LEN-1:0] instruction_out,
    output logic           valid_out
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [15:0]    fetch_count,
    output logic [15:0]    redirect_count
`endif
);

    localparam logic [LEN-1:0] ALIGN_MASK = {{(LEN-2){1'b1}}, 2'b00};
    localparam logic [LEN-1:0] WORD_STEP  = LEN'(4);

    logic [LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic           req_valid_q, req_valid_d;
    logic [LEN-1:0] req_pc_q, req_pc_d;
    logic           skid_valid_q, skid_valid_d;
    logic [LEN-1:0] skid_pc_q, skid_pc_d;
    logic [LEN-1:0] skid_instr_q, skid_instr_d;
    logic [LEN-1:0] pc_out_q, pc_out_d;
    logic [LEN-1:0] instr_out_q, instr_out_d;
    logic           valid_out_q, valid_out_d;

    logic           issue_en;
    logic [LEN-1:0] issue_addr;

    // Issue decision: branch redirect beats freeze, freeze beats sequential fetch.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        issue_en   = 1'b0;
        issue_addr = fetch_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (branch_taken) begin
            issue_en   = 1'b1;
            issue_addr = branch_addr & ALIGN_MASK;
            fetch_pc_d = (branch_addr & ALIGN_MASK) + WORD_STEP;
        end else if (!freeze) begin
            issue_en   = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD_STEP;
        end
    end

    // The memory must see no read while reset is held, even though the
    // issue logic would otherwise request one.
    assign imem_rd_en = issue_en & ~reset;
    assign imem_addr  = issue_addr;

    // Remember what was asked for so the response next cycle can be tagged.
    always_comb begin
        req_valid_d = issue_en;
        req_pc_d    = issue_addr;
    end

    // Output / skid update: the response lands either in IF/ID or, when
    // frozen, in the skid so it is not lost.
    always_comb begin
        pc_out_d     = pc_out_q;
        instr_out_d  = instr_out_q;
        valid_out_d  = valid_out_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (branch_taken) begin
            // In-flight response and any skidded one belong to the wrong path.
            valid_out_d  = 1'b0;
            instr_out_d  = '0;
            skid_valid_d = 1'b0;
        end else if (freeze) begin
            if (req_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_instr_d = imem_rdata;
            end
        end else if (skid_valid_q) begin
            pc_out_d     = skid_pc_q;
            instr_out_d  = skid_instr_q;
            valid_out_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (req_valid_q) begin
            pc_out_d    = req_pc_q;
            instr_out_d = imem_rdata;
            valid_out_d = 1'b1;
        end else begin
            valid_out_d = 1'b0;
            instr_out_d = '0;
        end
    end

    // Pipeline state; skid payload is reset too so a reset mid-freeze drops it cleanly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            pc_out_q     <= '0;
            instr_out_q  <= '0;
            valid_out_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fetch_pc_q   <= fetch_pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign pc_out          = pc_out_q;
    assign instruction_out = instr_out_q;
    assign valid_out       = valid_out_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] redirect_count_q, redirect_count_d;
    logic        deliver;

    // Saturating counters: a new instruction enters IF/ID only on an unfrozen,
    // non-redirect edge with something pending.
    always_comb begin
        deliver          = !branch_taken && !freeze && (skid_valid_q || req_valid_q);
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (deliver && fetch_count_q != 16'hFFFF)
            fetch_count_d = fetch_count_q + 16'd1;
        if (branch_taken && redirect_count_q != 16'hFFFF)
            redirect_count_d = redirect_count_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule
